// File: rtl/seg_score_reader.sv
// Seven-segment scoreboard monitor: debounces the tens/ones digit buses, decodes them to a score and
// classifies every committed change as a step, a clear or a jump. All outputs are registered.
module seg_score_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk_1khz_i,
  input  logic       rst_i,
  input  logic [6:0] seg_tens_i,
  input  logic [6:0] seg_ones_i,
  output logic [6:0] score_o,
  output logic       score_valid_o,
  output logic       update_o,
  output logic       step_o,
  output logic       clear_o,
  output logic       jump_o,
  output logic       invalid_o
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  typedef enum logic {S_EMPTY, S_TRACK} state_e;

  // Returns {valid, digit}; blank is accepted as zero only where leading-zero suppression applies.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg, input logic blank_is_zero);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = 5'h10;
      7'h06:   res = 5'h11;
      7'h5B:   res = 5'h12;
      7'h4F:   res = 5'h13;
      7'h66:   res = 5'h14;
      7'h6D:   res = 5'h15;
      7'h7D:   res = 5'h16;
      7'h07:   res = 5'h17;
      7'h7F:   res = 5'h18;
      7'h6F:   res = 5'h19;
      7'h00:   res = blank_is_zero ? 5'h10 : 5'h00;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [13:0] pair_in;
  logic [13:0] sample_q, sample_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        committed_q, committed_d;
  state_e      state_q, state_d;
  logic [6:0]  score_q, score_d;
  logic        invalid_q, invalid_d;
  logic        update_q, update_d;
  logic        step_q, step_d;
  logic        clear_q, clear_d;
  logic        jump_q, jump_d;

  logic        commit;
  logic [6:0]  tens_hi, ones_hi;
  logic [4:0]  tens_dec, ones_dec;
  logic        pair_valid;
  logic [6:0]  new_score;

  assign pair_in = {seg_tens_i, seg_ones_i};

  // Decode from sample_q: at a commit it equals the incoming pair, and it keeps the path register-fed.
  assign tens_hi    = ACTIVE_LOW ? ~sample_q[13:7] : sample_q[13:7];
  assign ones_hi    = ACTIVE_LOW ? ~sample_q[6:0]  : sample_q[6:0];
  assign tens_dec   = seg_decode(tens_hi, 1'b1);
  assign ones_dec   = seg_decode(ones_hi, 1'b0);
  assign pair_valid = tens_dec[4] & ones_dec[4];
  assign new_score  = 7'(tens_dec[3:0]) * 7'd10 + 7'(ones_dec[3:0]);

  assign commit = (cnt_q == CNT_MAX) && (pair_in == sample_q) && !committed_q;

  always_comb begin
    sample_d    = pair_in;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    if (pair_in != sample_q) begin
      cnt_d       = 4'd0;
      committed_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (commit) begin
        committed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (commit && pair_valid) begin
      state_d = S_TRACK;
    end
  end

  always_comb begin
    score_d   = score_q;
    invalid_d = invalid_q;
    update_d  = 1'b0;
    step_d    = 1'b0;
    clear_d   = 1'b0;
    jump_d    = 1'b0;
    if (commit) begin
      if (!pair_valid) begin
        invalid_d = 1'b1;
      end else begin
        invalid_d = 1'b0;
        // Recommitting the score already shown (e.g. after a glitch) stays silent.
        if (!(state_q == S_TRACK && new_score == score_q)) begin
          score_d  = new_score;
          update_d = 1'b1;
          if (state_q == S_TRACK) begin
            if (new_score == score_q + 7'd1) begin
              step_d = 1'b1;
            end else if (new_score == 7'd0) begin
              clear_d = 1'b1;
            end else begin
              jump_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      sample_q    <= '0;
      cnt_q       <= '0;
      committed_q <= 1'b0;
      score_q     <= '0;
      invalid_q   <= 1'b0;
      update_q    <= 1'b0;
      step_q      <= 1'b0;
      clear_q     <= 1'b0;
      jump_q      <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      score_q     <= score_d;
      invalid_q   <= invalid_d;
      update_q    <= update_d;
      step_q      <= step_d;
      clear_q     <= clear_d;
      jump_q      <= jump_d;
    end
  end

  assign score_o       = score_q;
  assign score_valid_o = (state_q == S_TRACK);
  assign update_o      = update_q;
  assign step_o        = step_q;
  assign clear_o       = clear_q;
  assign jump_o        = jump_q;
  assign invalid_o     = invalid_q;

endmodule

// File: tb/tb_seg_score_reader.sv
// Bench for seg_score_reader: directed scenarios with literal expectations plus random patterns
// checked every cycle against a run-length model of the display.
module tb_seg_score_reader;
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] tens, ones;
  logic [6:0] score_o;
  logic       score_valid_o, update_o, step_o, clear_o, jump_o, invalid_o;

  always #5 clk = ~clk;

  seg_score_reader #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut (
    .clk_1khz_i(clk), .rst_i(rst), .seg_tens_i(tens), .seg_ones_i(ones),
    .score_o(score_o), .score_valid_o(score_valid_o), .update_o(update_o),
    .step_o(step_o), .clear_o(clear_o), .jump_o(jump_o), .invalid_o(invalid_o)
  );

  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dec(input logic [6:0] s, input bit tens_pos);
    for (int i = 0; i < 10; i++) if (codes[i] == s) return i;
    if (tens_pos && s == 7'h00) return 0;
    return -1;
  endfunction

  // Model: a pattern commits when it has been seen at exactly SC+1 consecutive edges.
  // Reset leaves the all-zero pattern counted as already seen once.
  logic [13:0] m_last;
  int m_run, m_score;
  bit m_valid, m_inv, m_upd, m_stp, m_clr, m_jmp;

  always @(posedge clk) begin
    int t, o, n;
    if (rst) begin
      m_last = '0; m_run = 1; m_score = 0;
      m_valid = 0; m_inv = 0; m_upd = 0; m_stp = 0; m_clr = 0; m_jmp = 0;
    end else begin
      m_upd = 0; m_stp = 0; m_clr = 0; m_jmp = 0;
      if ({tens, ones} == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = {tens, ones};
        m_run = 1;
      end
      if (m_run == SC + 1) begin
        t = dec(tens, 1'b1);
        o = dec(ones, 1'b0);
        if (t < 0 || o < 0) begin
          m_inv = 1;
        end else begin
          n = t * 10 + o;
          m_inv = 0;
          if (!(m_valid && n == m_score)) begin
            if (m_valid) begin
              if (n == m_score + 1) m_stp = 1;
              else if (n == 0) m_clr = 1;
              else m_jmp = 1;
            end
            m_upd = 1;
            m_score = n;
            m_valid = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("outputs{score,vld,upd,stp,clr,jmp,inv}",
          {score_o, score_valid_o, update_o, step_o, clear_o, jump_o, invalid_o},
          {7'(m_score), m_valid, m_upd, m_stp, m_clr, m_jmp, m_inv});
  end

  int w_upd, w_at, w_stp, w_clr, w_jmp;

  task automatic watch(input int n);
    w_upd = 0; w_at = 0; w_stp = 0; w_clr = 0; w_jmp = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (update_o === 1'b1) begin
        w_upd++;
        if (w_at == 0) w_at = i;
      end
      if (step_o === 1'b1) w_stp++;
      if (clear_o === 1'b1) w_clr++;
      if (jump_o === 1'b1) w_jmp++;
    end
  endtask

  task automatic put(input int s);
    tens = (s < 10) ? 7'h00 : codes[s / 10];
    ones = codes[s % 10];
  endtask

  initial begin
    int r, s, hold;
    logic [6:0] o;
    rst = 1'b1; tens = '0; ones = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_score", score_o, 0);
    chk("reset_valid", score_valid_o, 0);
    chk("reset_update", update_o, 0);
    chk("reset_invalid", invalid_o, 0);

    // First commit: blank tens + 0 on ones.
    rst = 1'b0; tens = 7'h00; ones = 7'h3F;
    watch(10);
    chk("first_upd_count", w_upd, 1);
    chk("first_upd_cycle", w_at, 5);
    chk("first_no_class", w_stp + w_clr + w_jmp, 0);
    chk("first_score", score_o, 0);
    chk("first_valid", score_valid_o, 1);

    put(41); watch(8);
    put(42); watch(8);
    chk("step_cycle", w_at, 5);
    chk("step_pulse", w_stp, 1);
    chk("step_score", score_o, 42);

    put(99); watch(8);
    tens = codes[0]; ones = codes[0]; watch(8);
    chk("clear_upd", w_upd, 1);
    chk("clear_pulse", w_clr, 1);
    chk("clear_score", score_o, 0);

    put(12); watch(8);
    put(30); watch(8);
    chk("jump_pulse", w_jmp, 1);
    chk("jump_score", score_o, 30);

    put(7); watch(8);
    put(8); watch(3);
    chk("glitch_upd_a", w_upd, 0);
    put(7); watch(8);
    chk("glitch_upd_b", w_upd, 0);
    chk("glitch_score", score_o, 7);

    put(23); watch(8);
    tens = codes[2]; ones = 7'h49; watch(8);
    chk("inv_flag", invalid_o, 1);
    chk("inv_score", score_o, 23);
    chk("inv_upd", w_upd, 0);
    put(24); watch(8);
    chk("inv_then_step", w_stp, 1);
    chk("inv_cleared", invalid_o, 0);

    put(50); watch(8);
    put(51); watch(2);
    rst = 1'b1; watch(1);
    chk("midrst_outputs",
        {score_o, score_valid_o, update_o, step_o, clear_o, jump_o, invalid_o}, 0);
    rst = 1'b0; watch(8);
    chk("midrst_upd_cycle", w_at, 5);
    chk("midrst_no_class", w_stp + w_clr + w_jmp, 0);
    chk("midrst_score", score_o, 51);

    repeat (300) begin
      r = $urandom_range(0, 99);
      hold = $urandom_range(1, 9);
      if (r < 4) begin
        rst = 1'b1; watch(1); rst = 1'b0;
      end else if (r < 55) begin
        put((m_score + 1) % 100);
      end else if (r < 65) begin
        tens = ($urandom_range(0, 1) != 0) ? codes[0] : 7'h00; ones = codes[0];
      end else if (r < 80) begin
        s = $urandom_range(0, 99); put(s);
      end else if (r < 90) begin
        do o = 7'($urandom_range(0, 127)); while (dec(o, 1'b0) >= 0);
        tens = codes[$urandom_range(0, 9)]; ones = o;
      end else begin
        tens = 7'($urandom_range(0, 127)); ones = 7'($urandom_range(0, 127));
      end
      watch(hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
